// File: rtl/unary_acc_pkg.sv
// unary_acc_pkg: shared types and constants for the unary-rate accumulator.
// Contents: FSM state enum, default operand/partial-sum widths,
//           and the maximum window length derived from the operand width.
package unary_acc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_W = 32;

  // A WIDTH-bit signed operand has a magnitude of at most 2^(WIDTH-1).
  // That bound is also the longest window.
  function automatic int max_win(input int width);
    return 1 << (width - 1);
  endfunction

  localparam int MAX_WIN = max_win(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PSUM  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/unary_acc_if.sv
// unary_acc_if: bundles the window-control, product-bit and partial-sum handshake signals.
// master: the upstream/downstream environment. It drives i_* and observes o_*.
// slave : the accumulator. It observes i_* and drives o_*.
interface unary_acc_if #(
  parameter int WIDTH = unary_acc_pkg::DEF_WIDTH,
  parameter int ACC_W = unary_acc_pkg::DEF_ACC_W
) ();

  logic             i_start;
  logic             i_sign;
  logic [WIDTH-2:0] i_len;
  logic             i_bit;
  logic [ACC_W-1:0] i_psum;
  logic             i_psum_valid;
  logic             o_psum_ready;
  logic [ACC_W-1:0] o_psum;
  logic             o_valid;
  logic             i_ready;
  logic             o_busy;

  modport master (
    output i_start, i_sign, i_len, i_bit, i_psum, i_psum_valid, i_ready,
    input  o_psum_ready, o_psum, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_sign, i_len, i_bit, i_psum, i_psum_valid, i_ready,
    output o_psum_ready, o_psum, o_valid, o_busy
  );

endinterface

// File: rtl/unary_bit_cnt.sv
// unary_bit_cnt: window counter. A down-counter tracks the cycles left in the window,
// and an up-counter counts the product bits seen.
// Ports: clk, rst (async, active high), load/len start a window, en/bit_in advance it,
//        count is the ones tally, done flags the last cycle of the window (remaining==1).
module unary_bit_cnt
  import unary_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-2:0] len,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] WIN_MAX = WIDTH'(max_win(WIDTH));

  logic [WIDTH-1:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      count     <= '0;
    end else if (load) begin
      // A length of 0 encodes the full window, which does not fit in WIDTH-1 bits.
      remaining <= (len == '0) ? WIN_MAX : {1'b0, len};
      count     <= '0;
    end else if (en) begin
      // count cannot overflow: it is bounded by the window length, which is at most 2^(WIDTH-1).
      count     <= count + {{(WIDTH-1){1'b0}}, bit_in};
      remaining <= remaining - WIDTH'(1);
    end
  end

  assign done = (remaining == WIDTH'(1));

endmodule

// File: rtl/unary_acc.sv
// unary_acc: counts a unary product bitstream over a programmable window, applies the sign,
// and adds the result to an incoming partial sum. The result is presented under valid/ready.
// Ports: clk, rst (async, active high), bus (unary_acc_if.slave): start/sign/len/bit in,
//        psum in with valid/ready, psum out with valid/ready, busy.
module unary_acc
  import unary_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic        clk,
  input  logic        rst,
  unary_acc_if.slave  bus
);

  state_t state_q, state_d;

  logic             cnt_load;
  logic             cnt_en;
  logic             psum_load;
  logic             cnt_done;
  logic [WIDTH-1:0] count;
  logic             sign_q;
  logic [ACC_W-1:0] psum_q;
  logic [ACC_W-1:0] cnt_ext;
  logic [ACC_W-1:0] addend;

  unary_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .len    (bus.i_len),
    .en     (cnt_en),
    .bit_in (bus.i_bit),
    .count  (count),
    .done   (cnt_done)
  );

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    psum_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          cnt_load = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        cnt_en = 1'b1;
        if (cnt_done) state_d = PSUM;
      end
      PSUM: begin
        if (bus.i_psum_valid) begin
          psum_load = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // count is zero-extended before negation, so a full window gives -2^(WIDTH-1) exactly.
  assign cnt_ext = ACC_W'(count);
  assign addend  = sign_q ? (-cnt_ext) : cnt_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      psum_q <= '0;
    end else begin
      if (cnt_load)  sign_q <= bus.i_sign;
      if (psum_load) psum_q <= bus.i_psum + addend;  // wraps modulo 2^ACC_W
    end
  end

  // Outputs come only from registers or are decoded from the state, never from the handshake inputs.
  assign bus.o_psum       = psum_q;
  assign bus.o_valid      = (state_q == OUT);
  assign bus.o_psum_ready = (state_q == PSUM);
  assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_unary_acc.sv
module tb_unary_acc;
  import unary_acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unary_acc_if #(.WIDTH(16), .ACC_W(32)) bus_if ();

  unary_acc #(.WIDTH(16), .ACC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit bits_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance one cycle; act 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full window using the bits in bits_q. The expected result is computed from the
  // arithmetic meaning: psum +/- number of ones in the window.
  task automatic window(input logic s, input int L, input logic [31:0] psum,
                        input int psum_dly, input int rdy_dly, input string tag);
    logic [31:0] ones;
    logic [31:0] exp;
    ones = 0;
    foreach (bits_q[i]) ones += 32'(bits_q[i]);
    exp = s ? (psum - ones) : (psum + ones);

    // cycle 0: IDLE, issue start. The bit in this cycle must not be counted.
    check({tag, ":idle_busy"}, 32'(bus_if.o_busy), 0);
    bus_if.i_start = 1'b1;
    bus_if.i_sign  = s;
    bus_if.i_len   = (L == 32768) ? 15'd0 : 15'(L);
    bus_if.i_bit   = 1'b1;
    step();
    for (int k = 0; k < L; k++) begin
      // Pulses of start and psum_valid during ACCUM must be ignored.
      bus_if.i_start      = 1'($urandom_range(0, 1));
      bus_if.i_psum_valid = 1'($urandom_range(0, 1));
      bus_if.i_psum       = $urandom;
      bus_if.i_bit        = bits_q[k];
      if (k == 0)     check({tag, ":accum_busy"}, 32'(bus_if.o_busy), 1);
      if (k == L - 1) check({tag, ":accum_rdy"}, 32'(bus_if.o_psum_ready), 0);
      step();
    end
    // cycle L+1: PSUM
    bus_if.i_start      = 1'b0;
    bus_if.i_psum_valid = 1'b0;
    bus_if.i_bit        = 1'($urandom_range(0, 1));
    check({tag, ":psum_rdy"}, 32'(bus_if.o_psum_ready), 1);
    for (int d = 0; d < psum_dly; d++) begin
      step();
      check({tag, ":psum_wait_valid"}, 32'(bus_if.o_valid), 0);
    end
    bus_if.i_psum_valid = 1'b1;
    bus_if.i_psum       = psum;
    step();
    // OUT
    bus_if.i_psum_valid = 1'b0;
    bus_if.i_psum       = $urandom;
    bus_if.i_ready      = 1'b0;
    check({tag, ":valid"}, 32'(bus_if.o_valid), 1);
    check({tag, ":psum"}, bus_if.o_psum, exp);
    for (int d = 0; d < rdy_dly; d++) begin
      bus_if.i_start = 1'b1;  // must be ignored in OUT
      step();
      check({tag, ":bp_valid"}, 32'(bus_if.o_valid), 1);
      check({tag, ":bp_psum"}, bus_if.o_psum, exp);
      check({tag, ":bp_busy"}, 32'(bus_if.o_busy), 1);
    end
    bus_if.i_start = 1'b0;
    bus_if.i_ready = 1'b1;
    step();
    bus_if.i_ready = 1'b0;
    check({tag, ":done_valid"}, 32'(bus_if.o_valid), 0);
    check({tag, ":done_busy"}, 32'(bus_if.o_busy), 0);
  endtask

  initial begin
    bus_if.i_start      = 1'b0;
    bus_if.i_sign       = 1'b0;
    bus_if.i_len        = '0;
    bus_if.i_bit        = 1'b0;
    bus_if.i_psum       = '0;
    bus_if.i_psum_valid = 1'b0;
    bus_if.i_ready      = 1'b0;

    // Reset state
    #2;
    check("rst_busy", 32'(bus_if.o_busy), 0);
    check("rst_valid", 32'(bus_if.o_valid), 0);
    check("rst_rdy", 32'(bus_if.o_psum_ready), 0);
    check("rst_psum", bus_if.o_psum, 0);
    step();
    rst = 1'b0;
    step();

    // Directed cases
    bits_q = '{1, 0, 1, 1, 0, 1, 1, 0};
    window(1'b0, 8, 32'd100, 0, 0, "pos");
    window(1'b1, 8, 32'd100, 0, 0, "neg");
    window(1'b1, 8, 32'hFFFF_FFFD, 2, 3, "neg_m3_bp");

    bits_q = '{1};
    window(1'b0, 1, 32'h7FFF_FFFF, 0, 1, "wrap");

    bits_q.delete();
    for (int i = 0; i < 32768; i++) bits_q.push_back(1'b1);
    window(1'b0, 32768, 32'd0, 0, 0, "maxwin");

    // Abort: reset in cycle 4 of an L=8 window
    bus_if.i_start = 1'b1;
    bus_if.i_sign  = 1'b0;
    bus_if.i_len   = 15'd8;
    step();
    bus_if.i_start = 1'b0;
    bus_if.i_bit   = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus_if.o_busy), 0);
    check("abort_valid", 32'(bus_if.o_valid), 0);
    check("abort_rdy", 32'(bus_if.o_psum_ready), 0);
    step();
    rst = 1'b0;
    step();
    bits_q = '{1, 1};
    window(1'b0, 2, 32'd0, 0, 0, "after_abort");

    // Randomized windows
    for (int t = 0; t < 20; t++) begin
      int L;
      L = $urandom_range(1, 40);
      bits_q.delete();
      for (int i = 0; i < L; i++) bits_q.push_back(1'($urandom_range(0, 1)));
      window(1'($urandom_range(0, 1)), L, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unary_acc.md
# unary_acc

Accumulator stage directly downstream of the unary-rate multiplier cell in the 16-bit systolic array. It counts the multiplier's product bitstream over one computation window of programmable length, applies the product sign, and adds the result to an incoming partial sum. The signed partial sum is then presented to the next PE or the array output under a valid/ready handshake.

## Interface
- WIDTH, 16: operand width including sign; maximum window is 2^(WIDTH-1) cycles.
- ACC_W, 32: partial-sum width, two's complement.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  starts a window; accepted only in IDLE.
- i_sign  in  1  product sign (sign_i XOR sign_w), sampled with i_start.
- i_len  in  WIDTH-1  window length in cycles, sampled with i_start; 0 encodes 2^(WIDTH-1).
- i_bit  in  1  multiplier product bit.
- i_psum  in  ACC_W  incoming signed partial sum.
- i_psum_valid  in  1  i_psum valid.
- o_psum_ready  out  1  block accepts i_psum.
- o_psum  out  ACC_W  outgoing signed partial sum.
- o_valid  out  1  o_psum valid.
- i_ready  in  1  consumer accepts o_psum.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, PSUM, OUT. Reset puts the FSM in IDLE with count=0, remaining=0, sign=0, o_psum=0, and all outputs low.
- IDLE: when i_start=1, latch sign, load remaining = (i_len==0 ? 2^(WIDTH-1) : i_len) (WIDTH bits), clear count, and go to ACCUM. i_bit is not counted in the i_start cycle.
- ACCUM: each cycle, count += i_bit and remaining -= 1. On the cycle remaining==1, that bit is counted and the FSM goes to PSUM. count is WIDTH bits unsigned and cannot overflow, because the maximum is 2^(WIDTH-1).
- PSUM: o_psum_ready=1. When i_psum_valid=1, register o_psum = i_psum + (sign ? -ext(count) : ext(count)), with count zero-extended to ACC_W before negation. Then go to OUT. The sum wraps modulo 2^ACC_W; there is no saturation.
- OUT: o_valid=1, and o_psum is held stable until i_ready=1. On the handshake, go to IDLE. o_valid deasserts the following cycle.
- i_start is ignored in ACCUM, PSUM and OUT. It is not queued.
- i_psum_valid outside PSUM is ignored. o_psum_ready is high only in PSUM.
- Reset mid-operation aborts immediately with no output. The partially counted window is discarded.

## Timing
- i_start is sampled at the end of cycle 0. i_bit is counted in cycles 1..L.
- o_psum_ready is high from cycle L+1.
- If i_psum_valid is high in cycle P ≥ L+1, o_valid and o_psum appear in cycle P+1.
- Minimum start-to-start period is L+3 cycles: the i_ready handshake in OUT at cycle L+2, IDLE at L+3, where a new i_start is accepted.
- All outputs are registered or decoded from the state register only. There is no combinational path from i_ready or i_psum_valid to any output.

## Structure
- Shared package unary_acc_pkg holds:
  - the FSM state enum type,
  - localparam MAX_WIN = 2^(WIDTH-1) as a function of WIDTH,
  - the default ACC_W.
- One sub-module, unary_bit_cnt, contains the window counter. It holds the remaining-cycle down-counter and the count up-counter, with load, enable and done (remaining==1) signals.
- The top level holds the FSM, the sign/psum adder, and the output register.

## Test plan
- L=8, sign=0, bit pattern 1,0,1,1,0,1,1,0 in cycles 1..8, i_psum=100 valid at cycle 9 -> o_valid in cycle 10, o_psum=105.
- Same pattern with sign=1 and i_psum=100 -> o_psum=95. With i_psum=-3, sign=1, count 5 -> o_psum=-8 (0xFFFFFFF8).
- i_len=0, i_bit=1 for every cycle, i_psum=0 -> o_psum_ready rises at cycle 32769, o_psum=32768.
- Backpressure: hold i_ready=0 for 3 cycles in OUT -> o_valid stays 1 and o_psum stays constant. An i_start pulsed during OUT is ignored, and o_busy stays 1 until the handshake.
- Wrap: i_psum=0x7FFFFFFF, count=1, sign=0 -> o_psum=0x80000000.
- Assert rst in cycle 4 of an L=8 window -> o_busy, o_valid and o_psum_ready all go 0 immediately. A subsequent i_start with L=2, bits 1,1, i_psum=0 -> o_psum=2, with no residue from the aborted window.
